// File: rtl/temporal_pkg.sv
// Shared types and helpers for the race-logic temporal blocks.
package temporal_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // All-ones code used to represent "no edge" (infinity) for a given width.
  function automatic logic [63:0] inf_code(input int unsigned width);
    if (width >= 64) begin
      inf_code = '1;
    end else begin
      inf_code = (64'd1 << width) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/race_out_buf.sv
// Single-entry valid/ready holding register. A result that arrives while
// an unaccepted result is still held is dropped and flagged on overrun_o.
module race_out_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic         overrun_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovr_q, ovr_d;
  logic         xfer;

  assign xfer = valid_q & out_ready_i;

  // Load on empty or on the accepting edge; otherwise drop and flag.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = 1'b0;
    if (in_valid_i) begin
      if (!valid_q || xfer) begin
        valid_d = 1'b1;
        data_d  = in_data_i;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign overrun_o   = ovr_q;

endmodule

// File: rtl/race_time_decoder.sv
// Converts the arrival time of one temporal edge within a gamma window into
// a binary timestamp (aclk cycles from window start), or infinity if no edge.
//
// state | meaning
// IDLE  | no window open, waiting for gamma_start
// RUN   | window open, count tracks window cycle t
module race_time_decoder
  import temporal_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAMMA_LEN = 16,
  parameter int RISING    = 1
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             gamma_start,
  input  logic             din,
  output logic [WIDTH-1:0] out_data,
  output logic             out_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] INF_CODE = WIDTH'(inf_code(WIDTH));
  localparam logic [WIDTH-1:0] LAST_T   = WIDTH'(GAMMA_LEN - 1);
  localparam logic             ACT_LVL  = (RISING != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             cap_q, cap_d;
  logic [WIDTH-1:0] ts_q, ts_d;

  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_inf;
  logic             active;
  logic [WIDTH:0]   buf_data;

  assign active = (din == ACT_LVL);

  // Next-state, counter and capture; emits the result on the final window cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cap_d     = cap_q;
    ts_d      = ts_q;
    res_valid = 1'b0;
    res_data  = '0;
    res_inf   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gamma_start) begin
          state_d = RUN;
          count_d = '0;
          cap_d   = 1'b0;
        end
      end
      RUN: begin
        if (count_q == LAST_T) begin
          // A capture on the last cycle itself still counts.
          res_valid = 1'b1;
          if (cap_q) begin
            res_data = ts_q;
          end else if (active) begin
            res_data = count_q;
          end else begin
            res_data = INF_CODE;
            res_inf  = 1'b1;
          end
          count_d = '0;
          cap_d   = 1'b0;
          state_d = gamma_start ? RUN : IDLE;
        end else if (gamma_start) begin
          // Mid-window restart: discard the window silently.
          count_d = '0;
          cap_d   = 1'b0;
        end else begin
          count_d = count_q + WIDTH'(1);
          if (!cap_q && active) begin
            cap_d = 1'b1;
            ts_d  = count_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter and timestamp registers.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state_q <= IDLE;
      count_q <= '0;
      cap_q   <= 1'b0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cap_q   <= cap_d;
      ts_q    <= ts_d;
    end
  end

  assign busy = (state_q == RUN);

  race_out_buf #(
    .W(WIDTH + 1)
  ) u_out_buf (
    .clk         (aclk),
    .rst_n       (grst),
    .in_valid_i  (res_valid),
    .in_data_i   ({res_inf, res_data}),
    .out_valid_o (out_valid),
    .out_data_o  (buf_data),
    .out_ready_i (out_ready),
    .overrun_o   (overrun)
  );

  assign out_inf  = buf_data[WIDTH];
  assign out_data = buf_data[WIDTH-1:0];

endmodule

// File: tb/tb_race_time_decoder.sv
// Directed bench: one rising-mode and one falling-mode decoder share clock,
// reset, gamma_start and out_ready; each has its own din.
module tb_race_time_decoder;

  logic       aclk = 1'b0;
  logic       grst;
  logic       gamma_start;
  logic       out_ready;
  logic       din_r, din_f;
  logic [7:0] data_r, data_f;
  logic       inf_r, inf_f, valid_r, valid_f, busy_r, busy_f, ovr_r, ovr_f;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  race_time_decoder #(.WIDTH(8), .GAMMA_LEN(16), .RISING(1)) dut_r (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .din(din_r),
    .out_data(data_r), .out_inf(inf_r), .out_valid(valid_r),
    .out_ready(out_ready), .busy(busy_r), .overrun(ovr_r)
  );

  race_time_decoder #(.WIDTH(8), .GAMMA_LEN(16), .RISING(0)) dut_f (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .din(din_f),
    .out_data(data_f), .out_inf(inf_f), .out_valid(valid_f),
    .out_ready(out_ready), .busy(busy_f), .overrun(ovr_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Open a window: gamma_start sampled on the next edge, din inactive.
  task automatic start();
    din_r       = 1'b0;
    din_f       = 1'b1;
    gamma_start = 1'b1;
    tick();
    gamma_start = 1'b0;
  endtask

  // Drive window cycles t0..t1; din active over [on, off). Optional
  // gamma_start on the last driven cycle.
  task automatic run(input int on_r, input int off_r, input int on_f, input int off_f,
                     input int t0, input int t1, input bit gs_last);
    for (int t = t0; t <= t1; t++) begin
      din_r       = (t >= on_r) && (t < off_r);
      din_f       = !((t >= on_f) && (t < off_f));
      gamma_start = gs_last && (t == t1);
      tick();
    end
    gamma_start = 1'b0;
  endtask

  task automatic idle();
    din_r = 1'b0;
    din_f = 1'b1;
    tick();
  endtask

  initial begin
    grst        = 1'b0;
    gamma_start = 1'b0;
    out_ready   = 1'b1;
    din_r       = 1'b0;
    din_f       = 1'b1;
    #12;
    chk("reset_valid", valid_r, 0);
    chk("reset_data", data_r, 0);
    chk("reset_inf", inf_r, 0);
    chk("reset_busy", busy_r, 0);
    chk("reset_ovr", ovr_r, 0);
    tick();
    grst = 1'b1;
    tick();

    // Rising edge at t=5
    start();
    chk("busy_after_start", busy_r, 1);
    run(5, 99, 99, 99, 0, 14, 0);
    chk("no_valid_before_end", valid_r, 0);
    run(5, 99, 99, 99, 15, 15, 0);
    chk("t5_valid", valid_r, 1);
    chk("t5_data", data_r, 5);
    chk("t5_inf", inf_r, 0);
    chk("fall_noedge_data", data_f, 255);
    chk("fall_noedge_inf", inf_f, 1);
    idle();
    chk("t5_valid_drop", valid_r, 0);
    chk("busy_idle", busy_r, 0);

    // No edge, t=0, t=15
    start();
    run(99, 99, 99, 99, 0, 15, 0);
    chk("inf_data", data_r, 255);
    chk("inf_flag", inf_r, 1);
    idle();
    start();
    run(0, 99, 99, 99, 0, 15, 0);
    chk("t0_data", data_r, 0);
    chk("t0_inf", inf_r, 0);
    idle();
    start();
    run(15, 99, 99, 99, 0, 15, 0);
    chk("t15_data", data_r, 15);
    chk("t15_valid", valid_r, 1);
    idle();

    // Falling mode: drop at 9; then low pulse at t=3 only
    start();
    run(99, 99, 9, 99, 0, 15, 0);
    chk("fall_t9_data", data_f, 9);
    chk("fall_t9_inf", inf_f, 0);
    idle();
    start();
    run(99, 99, 3, 4, 0, 15, 0);
    chk("fall_pulse_data", data_f, 3);
    chk("fall_pulse_valid", valid_f, 1);
    idle();
    // Rising din toggling after capture at 2
    start();
    run(2, 4, 99, 99, 0, 9, 0);
    run(12, 99, 99, 99, 10, 15, 0);
    chk("toggle_ignored", data_r, 2);
    idle();

    // Overrun with out_ready low
    out_ready = 1'b0;
    idle();
    start();
    run(2, 99, 99, 99, 0, 15, 0);
    chk("ovr_first_data", data_r, 2);
    chk("ovr_first_flag", ovr_r, 0);
    start();
    chk("ovr_hold_valid", valid_r, 1);
    run(7, 99, 99, 99, 0, 15, 0);
    chk("ovr_pulse", ovr_r, 1);
    chk("ovr_kept_data", data_r, 2);
    idle();
    chk("ovr_pulse_end", ovr_r, 0);
    chk("ovr_still_valid", valid_r, 1);
    out_ready = 1'b1;
    idle();
    chk("ovr_drain_empty", valid_r, 0);
    chk("ovr_drain_data", data_r, 2);

    // Abort at t=6 after capture at 4, then new window edge at t=1
    start();
    run(4, 99, 99, 99, 0, 6, 1);
    chk("abort_no_valid", valid_r, 0);
    chk("abort_busy", busy_r, 1);
    run(1, 99, 99, 99, 0, 14, 0);
    chk("abort_still_none", valid_r, 0);
    run(1, 99, 99, 99, 15, 15, 0);
    chk("abort_new_data", data_r, 1);
    chk("abort_no_ovr", ovr_r, 0);
    idle();

    // Overlap: gamma_start on final cycle
    start();
    run(3, 99, 99, 99, 0, 15, 1);
    chk("overlap_first_data", data_r, 3);
    chk("overlap_busy", busy_r, 1);
    run(10, 99, 99, 99, 0, 0, 0);
    chk("overlap_consumed", valid_r, 0);
    run(10, 99, 99, 99, 1, 15, 0);
    chk("overlap_second_data", data_r, 10);
    chk("overlap_second_valid", valid_r, 1);
    idle();

    // Reset mid-window at t=8
    start();
    run(3, 99, 99, 99, 0, 8, 0);
    #2 grst = 1'b0;
    #1;
    chk("rst_mid_busy", busy_r, 0);
    chk("rst_mid_valid", valid_r, 0);
    tick();
    grst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle();
      chk("rst_mid_no_result", valid_r, 0);
    end

    // Reset while a result is held
    out_ready = 1'b0;
    start();
    run(4, 99, 99, 99, 0, 15, 0);
    chk("rst_hold_pre", data_r, 4);
    #2 grst = 1'b0;
    #1;
    chk("rst_hold_valid", valid_r, 0);
    chk("rst_hold_data", data_r, 0);
    chk("rst_hold_inf", inf_r, 0);
    tick();
    grst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle();
      chk("rst_hold_no_result", valid_r, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/race_time_decoder.md
Name: race_time_decoder

Overview:
- Downstream consumer of the temporal (race-logic) operators such as max/min.
- Converts the arrival time of a single temporal edge on din into a binary timestamp.
- Timestamp is measured in aclk cycles relative to the start of a gamma window.
- Result is presented to the binary domain through a valid/ready output register. A window with no edge reports "infinity".

Parameters:
- WIDTH, 8, timestamp width; all-ones (2^WIDTH-1) is reserved as the infinity code.
- GAMMA_LEN, 16, aclk cycles per gamma window; legal range 1..2^WIDTH-1.
- RISING, 1, 1 = active level high (rising-edge encoding); 0 = active level low (falling-edge encoding).

Ports:
- aclk  in  1  clock; all state on posedge.
- grst  in  1  reset; asynchronous, active-low.
- gamma_start  in  1  single-cycle pulse that opens a new window.
- din  in  1  temporal input, synchronous to aclk; returns to its inactive level between windows.
- out_data  out  WIDTH  captured timestamp, or all-ones for infinity.
- out_inf  out  1  high when out_data encodes infinity (no edge in the window).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  window in progress.
- overrun  out  1  one-cycle pulse when a finished result is dropped.

Behaviour:
- Reset (grst low, asynchronous):
  - state=IDLE; count=0; captured flag=0.
  - out_valid=0, out_data=0, out_inf=0, busy=0, overrun=0.
  - Any window in flight is discarded; no result is emitted after reset releases.
- States: IDLE and RUN.
  - IDLE -> RUN on posedge with gamma_start=1.
  - RUN -> IDLE after the posedge at which count==GAMMA_LEN-1, unless gamma_start=1 on that same edge.
- Window timing:
  - gamma_start sampled at edge k makes edge k+1 window cycle t=0.
  - count increments by 1 per edge in RUN, from 0 to GAMMA_LEN-1. count never wraps.
  - busy = (state==RUN).
- Capture:
  - At each RUN edge with count==t, din is sampled.
  - The first t at which din equals its active level (din==RISING) is latched as the timestamp, and the captured flag is set.
  - Later samples in the same window are ignored, even if din toggles.
  - din already active at t=0 gives timestamp 0.
- Completion, at the edge where count==GAMMA_LEN-1 is processed:
  - The result is the latched timestamp, or infinity if nothing was captured.
  - A capture at t=GAMMA_LEN-1 itself counts.
  - Infinity drives out_data=all-ones and out_inf=1.
  - The result is written to the output register on that same edge, so out_valid rises one cycle after the last window cycle.
- Handshake:
  - A transfer occurs on an edge with out_valid && out_ready.
  - out_valid, out_data and out_inf stay stable until the transfer.
  - out_valid drops after the transfer unless a new result is loaded on that same edge, in which case out_valid stays 1 with the new data.
  - out_ready while out_valid=0 is ignored.
- Overrun:
  - A new result arriving while out_valid=1 and out_ready=0 is dropped; the old result is kept.
  - overrun pulses high for exactly one cycle, on the cycle after the drop.
- gamma_start while in RUN:
  - Mid-window: the current window is aborted with no result and no overrun. count restarts at 0 on the next edge and the captured flag clears.
  - On the final window cycle: the completing window's result is emitted normally, and the new window starts with t=0 on the next edge.
- Throughput: back-to-back windows, one result per GAMMA_LEN cycles, with no dead cycles.

Decomposition:
- Shared package temporal_pkg:
  - state enum {IDLE, RUN}.
  - function inf_code(WIDTH) returning all-ones.
  - Reused by the planned upstream encoder.
- One natural sub-module: race_out_buf.
  - Single-entry valid/ready holding register with overrun detection.
  - Parameterised on WIDTH+1 bits (data plus inf flag).
- race_time_decoder itself holds the FSM, counter and capture logic.

Test Plan:
- Rising mode, GAMMA_LEN=16, WIDTH=8: gamma_start, din rises at t=5 and stays high, out_ready=1 -> out_valid for 1 cycle, 1 cycle after t=15, out_data=5, out_inf=0.
- No edge in the window -> out_data=255, out_inf=1. Separately, din high at t=0 -> out_data=0. din rising at t=15 -> out_data=15.
- Falling mode (RISING=0): din idles high and drops at t=9; in a second window din pulses low at t=3 and high again at t=4 -> results 9 then 3. Later toggles are ignored.
- out_ready=0 over two back-to-back windows (t=2, then t=7) -> out_data holds 2, overrun pulses 1 cycle after the second window ends. After out_ready=1, one transfer of 2 occurs, then out_valid=0.
- Abort and overlap: gamma_start at t=6 with edge already captured at t=4 -> no result; the new window with edge at t=1 yields 1. gamma_start at t=15 -> both windows produce results, with no dead cycle between them.
- Reset mid-window at t=8 and while out_valid=1 -> all outputs 0 immediately (asynchronous); no result after grst releases until the next gamma_start.
